// File: rtl/parser_ingress_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | parser_ingress_arbiter: frame-granular round-robin AXI-S ingress  |
// | mux in front of the Ethernet parser, with over-length truncation. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module parser_ingress_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BEATS  = 1518
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cfg_enable,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   s_tdata,
  input  logic [NUM_PORTS-1:0]              s_tvalid,
  input  logic [NUM_PORTS-1:0]              s_tlast,
  output logic [NUM_PORTS-1:0]              s_tready,
  output logic [DATA_WIDTH-1:0]             m_tdata,
  output logic                              m_tvalid,
  output logic                              m_tlast,
  output logic                              m_tuser,
  input  logic                              m_tready,
  output logic [$clog2(NUM_PORTS)-1:0]      m_tdest,
  output logic                              busy,
  output logic [15:0]                       trunc_count
);

  localparam int GW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PASS = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t          state;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   next_grant;
  logic [CW-1:0]   beat_cnt;

  logic sel_valid;
  logic sel_last;
  logic at_limit;
  logic handshake;

  assign sel_valid = s_tvalid[grant];
  assign sel_last  = s_tlast[grant];
  assign at_limit  = (beat_cnt == LAST_BEAT);
  assign handshake = (state == S_PASS) && sel_valid && m_tready;

  // Walk downward so the requester closest above last_grant is assigned last and wins.
  always_comb begin
    next_grant = last_grant;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      if (s_tvalid[GW'((int'(last_grant) + k) % NUM_PORTS)])
        next_grant = GW'((int'(last_grant) + k) % NUM_PORTS);
    end
  end

  always_comb begin
    s_tready = '0;
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tuser  = 1'b0;
    case (state)
      S_PASS: begin
        s_tready[grant] = m_tready;
        m_tdata         = s_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
        m_tvalid        = sel_valid;
        m_tlast         = sel_last | at_limit;
        m_tuser         = at_limit & ~sel_last;
      end
      S_DROP: s_tready[grant] = 1'b1;
      default: ;
    endcase
  end

  assign m_tdest = grant;
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      grant       <= '0;
      last_grant  <= GW'(NUM_PORTS - 1);
      beat_cnt    <= '0;
      trunc_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_enable && |s_tvalid) begin
            grant    <= next_grant;
            beat_cnt <= '0;
            state    <= S_PASS;
          end
        end
        S_PASS: begin
          if (handshake) begin
            beat_cnt <= beat_cnt + CW'(1);
            if (sel_last) begin
              last_grant <= grant;
              state      <= S_IDLE;
            end else if (at_limit) begin
              last_grant <= grant;
              state      <= S_DROP;
              if (trunc_count != 16'hFFFF)
                trunc_count <= trunc_count + 16'd1;
            end
          end
        end
        S_DROP: begin
          if (sel_valid && sel_last)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
